// File: rtl/mips_controller_pkg.sv
// Shared constants and types for the TinyMIPS multicycle controller:
// opcodes, funct codes, ALU control codes, aluop classes and FSM state encodings.
package mips_controller_pkg;

  localparam int IR_BYTES = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [1:0] {
    SRCB_REG    = 2'b00,
    SRCB_ONE    = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_BRANCH = 2'b11
  } srcb_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsrc_t;

  typedef enum logic [3:0] {
    S_FETCH1  = 4'd0,
    S_FETCH2  = 4'd1,
    S_FETCH3  = 4'd2,
    S_FETCH4  = 4'd3,
    S_DECODE  = 4'd4,
    S_MEMADR  = 4'd5,
    S_LBRD    = 4'd6,
    S_LBWR    = 4'd7,
    S_SBWR    = 4'd8,
    S_RTYPEEX = 4'd9,
    S_RTYPEWR = 4'd10,
    S_BEQEX   = 4'd11,
    S_JEX     = 4'd12,
    S_ADDIEX  = 4'd13,
    S_ADDIWR  = 4'd14
  } state_t;

endpackage

// File: rtl/mips_controller_aludec.sv
// ALU control decoder: maps the FSM's aluop class and the R-type funct field
// to the 3-bit alucont code. Purely combinational.
module aludec
  import mips_controller_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucont
);

  // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
  always_comb begin
    alucont = ALU_ADD;
    case (aluop)
      ALUOP_SUB:   alucont = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucont = ALU_ADD;
          FN_SUB:  alucont = ALU_SUB;
          FN_AND:  alucont = ALU_AND;
          FN_OR:   alucont = ALU_OR;
          FN_SLT:  alucont = ALU_SLT;
          default: alucont = ALU_ADD;
        endcase
      end
      default:     alucont = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_controller.sv
// Multicycle control FSM for the 8-bit TinyMIPS datapath: byte-wide 4-cycle fetch,
// decode, execute, memory and writeback. Moore outputs; only pcen sees the live zero flag.
module mips_controller
  import mips_controller_pkg::*;
#(
  parameter int INSTR_BYTES = IR_BYTES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             op,
  input  logic [5:0]             funct,
  input  logic                   zero,
  output logic                   memread,
  output logic                   memwrite,
  output logic                   alusrca,
  output logic [1:0]             alusrcb,
  output logic                   memtoreg,
  output logic                   iord,
  output logic                   regdst,
  output logic                   regwrite,
  output logic [1:0]             pcsource,
  output logic                   pcen,
  output logic [INSTR_BYTES-1:0] irwrite,
  output logic [2:0]             alucont
);

  state_t state;
  state_t dec_state;
  aluop_t aluop;
  logic   pcwrite;
  logic   branch;
  logic   fetch;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH1;
    end else begin
      case (state)
        S_FETCH1:  state <= S_FETCH2;
        S_FETCH2:  state <= S_FETCH3;
        S_FETCH3:  state <= S_FETCH4;
        S_FETCH4:  state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LB, OP_SB: state <= S_MEMADR;
            OP_RTYPE:     state <= S_RTYPEEX;
            OP_BEQ:       state <= S_BEQEX;
            OP_J:         state <= S_JEX;
            OP_ADDI:      state <= S_ADDIEX;
            default:      state <= S_FETCH1;
          endcase
        end
        S_MEMADR:  state <= (op == OP_SB) ? S_SBWR : S_LBRD;
        S_LBRD:    state <= S_LBWR;
        S_RTYPEEX: state <= S_RTYPEWR;
        S_ADDIEX:  state <= S_ADDIWR;
        default:   state <= S_FETCH1;
      endcase
    end
  end

  // While reset is held the state flop may still hold a mid-instruction value,
  // so outputs decode as FETCH1 and all write strobes are suppressed.
  assign dec_state = reset ? S_FETCH1 : state;

  always_comb begin
    memread  = 1'b0;
    memwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = SRCB_REG;
    memtoreg = 1'b0;
    iord     = 1'b0;
    regdst   = 1'b0;
    regwrite = 1'b0;
    pcsource = PCSRC_ALU;
    irwrite  = '0;
    aluop    = ALUOP_ADD;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    fetch    = 1'b0;
    case (dec_state)
      S_FETCH1: begin fetch = 1'b1; irwrite[0] = 1'b1; end
      S_FETCH2: begin fetch = 1'b1; irwrite[1] = 1'b1; end
      S_FETCH3: begin fetch = 1'b1; irwrite[2] = 1'b1; end
      S_FETCH4: begin fetch = 1'b1; irwrite[3] = 1'b1; end
      S_DECODE:  alusrcb = SRCB_BRANCH;
      S_MEMADR: begin alusrca = 1'b1; alusrcb = SRCB_IMM; end
      S_LBRD:   begin memread = 1'b1; iord = 1'b1; end
      S_LBWR:   begin regwrite = 1'b1; memtoreg = 1'b1; end
      S_SBWR:   begin memwrite = 1'b1; iord = 1'b1; end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWR: begin regwrite = 1'b1; regdst = 1'b1; end
      S_BEQEX: begin
        alusrca  = 1'b1;
        aluop    = ALUOP_SUB;
        pcsource = PCSRC_ALUOUT;
        branch   = 1'b1;
      end
      S_JEX:    begin pcsource = PCSRC_JUMP; pcwrite = 1'b1; end
      S_ADDIEX: begin alusrca = 1'b1; alusrcb = SRCB_IMM; end
      S_ADDIWR:  regwrite = 1'b1;
      default: ;
    endcase
    if (fetch) begin
      memread = 1'b1;
      alusrcb = SRCB_ONE;
      pcwrite = 1'b1;
    end
    if (reset) begin
      irwrite  = '0;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
    end
  end

  assign pcen = pcwrite | (branch & zero);

  aludec u_aludec (
    .aluop   (aluop),
    .funct   (funct),
    .alucont (alucont)
  );

endmodule

// File: tb/tb_mips_controller.sv
// Self-checking bench for mips_controller: directed instruction table, reset corner
// sequences, and random instructions against a cycle-by-cycle behavioural model.
module tb_mips_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       memread, memwrite, alusrca, memtoreg, iord, regdst, regwrite, pcen;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] irwrite;
  logic [2:0] alucont;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mips_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memread(memread), .memwrite(memwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .memtoreg(memtoreg), .iord(iord), .regdst(regdst), .regwrite(regwrite),
    .pcsource(pcsource), .pcen(pcen), .irwrite(irwrite), .alucont(alucont)
  );

  typedef struct packed {
    logic       memread, memwrite, alusrca;
    logic [1:0] alusrcb;
    logic       memtoreg, iord, regdst, regwrite;
    logic [1:0] pcsource;
    logic       pcen;
    logic [3:0] irwrite;
    logic [2:0] alucont;
  } ctl_t;

  typedef struct {
    logic [5:0] op, funct;
    int         zero;
    int         lat, rw, mw, pc;
    logic [2:0] alu5;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic ctl_t sample();
    ctl_t c;
    c = '{memread, memwrite, alusrca, alusrcb, memtoreg, iord, regdst, regwrite,
          pcsource, pcen, irwrite, alucont};
    return c;
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic int latency(input logic [5:0] o);
    case (o)
      6'b100000:                   return 8;
      6'b101000, 6'b000000, 6'b001000: return 7;
      6'b000100, 6'b000010:        return 6;
      default:                     return 5;
    endcase
  endfunction

  // Expected controls for cycle k (0-based) of an instruction with opcode o.
  function automatic ctl_t model(input logic [5:0] o, input logic [5:0] f,
                                 input logic z, input int k);
    ctl_t c;
    c = '0;
    c.alucont = 3'b010;
    if (k < 4) begin
      c.memread = 1'b1; c.alusrcb = 2'b01; c.pcen = 1'b1;
      c.irwrite = 4'(1 << k);
    end else if (k == 4) begin
      c.alusrcb = 2'b11;
    end else begin
      case (o)
        6'b100000, 6'b101000: begin
          if (k == 5) begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
          else if (o == 6'b101000) begin c.memwrite = 1'b1; c.iord = 1'b1; end
          else if (k == 6) begin c.memread = 1'b1; c.iord = 1'b1; end
          else begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
        end
        6'b000000: begin
          if (k == 5) begin c.alusrca = 1'b1; c.alucont = funct_alu(f); end
          else begin c.regwrite = 1'b1; c.regdst = 1'b1; end
        end
        6'b000100: begin
          c.alusrca = 1'b1; c.alucont = 3'b110; c.pcsource = 2'b01; c.pcen = z;
        end
        6'b000010: begin c.pcsource = 2'b10; c.pcen = 1'b1; end
        6'b001000: begin
          if (k == 5) begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
          else c.regwrite = 1'b1;
        end
        default: ;
      endcase
    end
    return c;
  endfunction

  // Entered during a FETCH1 cycle; returns during the following FETCH1 cycle.
  // zmode 0/1 holds zero fixed, 2 randomises it every cycle.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode,
                           output int lat, output int rw, output int mw, output int pc,
                           output logic [2:0] alu5);
    ctl_t got, exp;
    int   mlat;
    op = o; funct = f;
    lat = -1; rw = 0; mw = 0; pc = 0; alu5 = 3'b010;
    mlat = latency(o);
    for (int k = 0; k < 12; k++) begin
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      #1;
      got = sample();
      if (k > 0 && got.irwrite == 4'b0001) begin
        lat = k;
        break;
      end
      if (k < mlat) begin
        exp = model(o, f, zero, k);
        check($sformatf("ctl op=%b fn=%b k=%0d", o, f, k), {12'd0, got}, {12'd0, exp});
      end
      rw += int'(got.regwrite);
      mw += int'(got.memwrite);
      pc += int'(got.pcen);
      if (k == 5) alu5 = got.alucont;
      @(posedge clk);
    end
  endtask

  vec_t       tbl[13];
  int         lat, rw, mw, pc;
  logic [2:0] alu5;
  logic [5:0] rop, rfn;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{6'b000000, 6'b100010, 0, 7, 1, 0, 4, 3'b110};
    tbl[1]  = '{6'b000000, 6'b100000, 0, 7, 1, 0, 4, 3'b010};
    tbl[2]  = '{6'b000000, 6'b100100, 0, 7, 1, 0, 4, 3'b000};
    tbl[3]  = '{6'b000000, 6'b100101, 0, 7, 1, 0, 4, 3'b001};
    tbl[4]  = '{6'b000000, 6'b101010, 0, 7, 1, 0, 4, 3'b111};
    tbl[5]  = '{6'b000000, 6'b111111, 0, 7, 1, 0, 4, 3'b010};
    tbl[6]  = '{6'b000100, 6'b000000, 1, 6, 0, 0, 5, 3'b110};
    tbl[7]  = '{6'b000100, 6'b000000, 0, 6, 0, 0, 4, 3'b110};
    tbl[8]  = '{6'b100000, 6'b000000, 0, 8, 1, 0, 4, 3'b010};
    tbl[9]  = '{6'b101000, 6'b000000, 0, 7, 0, 1, 4, 3'b010};
    tbl[10] = '{6'b000010, 6'b000000, 0, 6, 0, 0, 5, 3'b010};
    tbl[11] = '{6'b001000, 6'b000000, 0, 7, 1, 0, 4, 3'b010};
    tbl[12] = '{6'b111111, 6'b000000, 0, 5, 0, 0, 4, 3'b010};

    reset = 1'b1; op = 6'b000000; funct = 6'b000000; zero = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check($sformatf("reset%0d pcen", c), 32'(pcen), 32'd0);
      check($sformatf("reset%0d irwrite", c), 32'(irwrite), 32'd0);
      check($sformatf("reset%0d wr", c), 32'({regwrite, memwrite}), 32'd0);
      check($sformatf("reset%0d fetch1 decode", c), 32'({memread, alusrcb}), 32'b101);
    end
    reset = 1'b0;

    foreach (tbl[i]) begin
      run_instr(tbl[i].op, tbl[i].funct, tbl[i].zero, lat, rw, mw, pc, alu5);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(tbl[i].lat));
      check($sformatf("vec%0d regwrites", i), 32'(rw), 32'(tbl[i].rw));
      check($sformatf("vec%0d memwrites", i), 32'(mw), 32'(tbl[i].mw));
      check($sformatf("vec%0d pcen cycles", i), 32'(pc), 32'(tbl[i].pc));
      check($sformatf("vec%0d alucont k5", i), 32'(alu5), 32'(tbl[i].alu5));
    end

    // Reset arriving during the load-byte read must drop the pending register write.
    op = 6'b100000; funct = 6'b000000; zero = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("lbrd read strobe", 32'({memread, iord}), 32'b11);
    reset = 1'b1;
    #1;
    check("lbrd reset strobes", 32'({regwrite, memwrite, pcen, irwrite}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("after reset fetch1", 32'(irwrite), 32'b0001);
    check("after reset no regwrite", 32'(regwrite), 32'd0);
    run_instr(6'b000010, 6'b000000, 0, lat, rw, mw, pc, alu5);
    check("j after reset latency", 32'(lat), 32'd6);
    check("j after reset pcen cycles", 32'(pc), 32'd5);

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 7))
        0: rop = 6'b100000;
        1: rop = 6'b101000;
        2: rop = 6'b000000;
        3: rop = 6'b000100;
        4: rop = 6'b000010;
        5: rop = 6'b001000;
        default: rop = 6'($urandom_range(0, 63));
      endcase
      case ($urandom_range(0, 5))
        0: rfn = 6'b100000;
        1: rfn = 6'b100010;
        2: rfn = 6'b100100;
        3: rfn = 6'b100101;
        4: rfn = 6'b101010;
        default: rfn = 6'($urandom_range(0, 63));
      endcase
      run_instr(rop, rfn, 2, lat, rw, mw, pc, alu5);
      check($sformatf("rand%0d op=%b latency", n, rop), 32'(lat), 32'(latency(rop)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
